cnt_ctrl: RTL and testbench
===========================

CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 The block SHALL use a single clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 The block SHALL have exactly the following ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous reset, active low
- timer_en  input  1  counting enable
- div_en  input  1  prescaler enable
- div_val  input  4  prescaler exponent
- halt_req  input  1  debug halt request
- dbg_mode  input  1  debug mode qualifier for halt_req
- tdr0_wr_sel  input  1  write strobe for cnt[31:0]
- tdr1_wr_sel  input  1  write strobe for cnt[63:32]
- pwdata  input  32  write data
- cnt  output  64  counter value
- cnt_en  output  1  registered one-cycle pulse, high in the cycle cnt shows an incremented value
- halt_ack  output  1  halt acknowledge
- state  output  2  current FSM state (IDLE=0, RUN=1, HALT=2)

Function
REQ-003 The FSM SHALL have three states:
- IDLE: timer_en=0.
- RUN: counting.
- HALT: counting frozen.
- Encoding 3 is unused and SHALL recover to IDLE on the next edge.
REQ-004 FSM transitions SHALL be:
- IDLE->RUN when timer_en=1.
- RUN->HALT when halt_req=1 and dbg_mode=1.
- HALT->RUN when halt_req=0 and timer_en=1.
- RUN or HALT->IDLE when timer_en=0; this takes priority over every other transition.
REQ-005 The internal prescaler counter div_cnt SHALL be 8 bits wide.
REQ-006 Effective divide ratio:
- div_en=0: ratio 1 (one tick per cycle).
- div_en=1: ratio 2^min(div_val,8); div_val values 9..15 SHALL behave as 8.
REQ-007 In RUN, div_cnt SHALL increment each cycle and wrap to 0 on reaching ratio-1; a tick occurs in the cycle div_cnt equals ratio-1 (every cycle when the ratio is 1).
REQ-008 On each tick, cnt SHALL increment by 1 on the next edge, and cnt_en SHALL be 1 in the cycle cnt shows the new value.
REQ-009 Counter latency from entering RUN (ratio 1) SHALL be: first increment visible one cycle after state=RUN.
REQ-010 cnt SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with cnt_en=1 and no other side effect.
REQ-011 In HALT, cnt and div_cnt SHALL hold, cnt_en SHALL be 0, and halt_ack SHALL be 1; halt_ack SHALL be 0 in all other states.
REQ-012 On leaving HALT, counting SHALL resume from the held div_cnt, with no lost or extra tick.
REQ-013 In IDLE, div_cnt SHALL be 0 and cnt_en SHALL be 0.
REQ-014 On the edge on which the state enters IDLE from RUN or HALT, cnt SHALL be cleared to 0.
REQ-015 Register writes:
- tdr0_wr_sel=1 SHALL load pwdata into cnt[31:0]; tdr1_wr_sel=1 SHALL load pwdata into cnt[63:32].
- Both high in the same cycle SHALL load both halves with pwdata.
- Writes SHALL be accepted in every state.
REQ-016 A write SHALL take priority over a tick in the same cycle: the whole of cnt takes only the written value(s), the tick is discarded, cnt_en=0, and div_cnt advances normally.
REQ-017 A write in the same cycle as a RUN/HALT->IDLE transition SHALL lose; cnt becomes 0.
REQ-018 Changes to div_en or div_val during RUN SHALL take effect on the next cycle; if div_cnt >= the new ratio-1, div_cnt SHALL wrap to 0 and a tick SHALL be generated in that cycle.
REQ-019 halt_req with dbg_mode=0 SHALL be ignored; dbg_mode falling while in HALT SHALL NOT force exit (the exit condition is halt_req=0 only).

Reset
REQ-020 While rst_n=0, asynchronously: state=IDLE, cnt=0, div_cnt=0, cnt_en=0, halt_ack=0.
REQ-021 Reset asserted mid-count or mid-halt SHALL discard all state; after release, the block SHALL start from IDLE and follow REQ-004.

Verification
REQ-022 Stimulus: reset, timer_en=1, div_en=0, run 10 cycles -> cnt=10, cnt_en high every cycle after the first.
REQ-023 Stimulus: div_en=1, div_val=2, run 16 cycles from IDLE -> cnt=4, cnt_en pulses exactly 4 cycles apart; with div_val=12 -> period 256.
REQ-024 Stimulus: write tdr1=0xFFFF_FFFF and tdr0=0xFFFF_FFFE in IDLE, then timer_en=1, div_en=0 -> cnt goes ...FFFE, ...FFFF, 0, 1, with cnt_en=1 at the wrap.
REQ-025 Stimulus: count to 5, assert dbg_mode=1 and halt_req=1 for 7 cycles, then release -> halt_ack=1 for 7 cycles, cnt holds 5 (or 6 if a tick was already in flight), then resumes at +1 per cycle.
REQ-026 Stimulus: tdr0_wr_sel with pwdata=0x100 in the same cycle as a tick -> cnt[31:0]=0x100, cnt_en=0; the next tick gives 0x101.
REQ-027 Stimulus: timer_en 1->0 with tdr0 write in the same cycle -> state=IDLE, cnt=0; rst_n pulse mid-HALT -> all outputs 0 immediately.

Source files
------------

// File: rtl/cnt_ctrl.sv
// 64-bit free-running counter with power-of-two prescaler, debug halt and
// software-writable halves. Three-state control FSM: IDLE, RUN, HALT.
module cnt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    input  logic        dbg_mode,
    input  logic        tdr0_wr_sel,
    input  logic        tdr1_wr_sel,
    input  logic [31:0] pwdata,
    output logic [63:0] cnt,
    output logic        cnt_en,
    output logic        halt_ack,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] cnt_q, cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        cnt_en_q, cnt_en_d;
    logic        halt_ack_q, halt_ack_d;

    logic [3:0]  exp_clamp;
    logic [7:0]  ratio_m1;
    logic        run_cycle;
    logic        tick;
    logic        wr_any;
    logic        to_idle;

    // Prescaler terminal count: 2^min(div_val,8) - 1, or 0 when bypassed.
    assign exp_clamp = (div_val > 4'd8) ? 4'd8 : div_val;
    assign ratio_m1  = div_en ? (8'hFF >> (4'd8 - exp_clamp)) : 8'd0;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = timer_en ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!timer_en)                state_d = ST_IDLE;
                else if (halt_req && dbg_mode) state_d = ST_HALT;
                else                          state_d = ST_RUN;
            end
            ST_HALT: begin
                if (!timer_en)     state_d = ST_IDLE;
                else if (!halt_req) state_d = ST_RUN;
                else               state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counting only happens in cycles that start and stay in RUN, so the
    // prescaler freezes on the exact edge the FSM leaves RUN and nothing is lost.
    assign run_cycle = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign tick      = run_cycle && (div_cnt_q >= ratio_m1);
    assign wr_any    = tdr0_wr_sel | tdr1_wr_sel;
    assign to_idle   = (state_d == ST_IDLE) &&
                       ((state_q == ST_RUN) || (state_q == ST_HALT));

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (state_d == ST_IDLE) begin
            div_cnt_d = 8'd0;
        end else if (run_cycle) begin
            div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
        end
    end

    // Clearing on entry to IDLE beats a write, which beats a tick.
    always_comb begin
        cnt_d = cnt_q;
        if (to_idle) begin
            cnt_d = 64'd0;
        end else if (wr_any) begin
            if (tdr0_wr_sel) cnt_d[31:0]  = pwdata;
            if (tdr1_wr_sel) cnt_d[63:32] = pwdata;
        end else if (tick) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    assign cnt_en_d   = tick && !wr_any;
    assign halt_ack_d = (state_d == ST_HALT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 64'd0;
            div_cnt_q  <= 8'd0;
            cnt_en_q   <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cnt_q  <= div_cnt_d;
            cnt_en_q   <= cnt_en_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_en   = cnt_en_q;
    assign halt_ack = halt_ack_q;
    assign state    = state_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl: each scenario pushes the expected
// {state, halt_ack, cnt_en, cnt} for the next edge, then pops and compares.
module tb_cnt_ctrl;

    typedef logic [67:0] obs_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        halt_req;
    logic        dbg_mode;
    logic        tdr0_wr_sel;
    logic        tdr1_wr_sel;
    logic [31:0] pwdata;
    logic [63:0] cnt;
    logic        cnt_en;
    logic        halt_ack;
    logic [1:0]  state;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    cnt_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timer_en    (timer_en),
        .div_en      (div_en),
        .div_val     (div_val),
        .halt_req    (halt_req),
        .dbg_mode    (dbg_mode),
        .tdr0_wr_sel (tdr0_wr_sel),
        .tdr1_wr_sel (tdr1_wr_sel),
        .pwdata      (pwdata),
        .cnt         (cnt),
        .cnt_en      (cnt_en),
        .halt_ack    (halt_ack),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [1:0] st, input logic ack,
                                input logic en, input logic [63:0] c);
        return {st, ack, en, c};
    endfunction

    function automatic obs_t cur();
        return {state, halt_ack, cnt_en, cnt};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, got;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin rst_n = 1'b0; timer_en = 1'b1; end
            if (k == 3) begin rst_n = 1'b1; timer_en = 1'b0; end
            sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            if (k == 0) #2; else cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
    endtask

    task automatic test_basic_count();
        obs_t e, got;
        div_en = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k <= 10) begin
                timer_en = 1'b1;
                sb_q.push_back(mk(S_RUN, 1'b0, k > 0, 64'(k)));
            end else begin
                timer_en = 1'b0;
                sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            end
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL basic_count[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
    endtask

    task automatic test_prescale();
        obs_t e, got;
        int   j;
        div_en = 1'b1;
        for (int k = 0; k < 540; k++) begin
            if (k <= 16) begin
                div_val = 4'd2; timer_en = 1'b1;
                sb_q.push_back(mk(S_RUN, 1'b0, (k > 0) && (k % 4 == 0), 64'(k / 4)));
            end else if (k == 17 || k == 539) begin
                timer_en = 1'b0;
                sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            end else begin
                j = k - 18;
                div_val = 4'd12; timer_en = 1'b1;
                sb_q.push_back(mk(S_RUN, 1'b0, (j > 0) && (j % 256 == 0), 64'(j / 256)));
            end
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL prescale[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
        div_en = 1'b0; div_val = 4'd0;
    endtask

    task automatic test_div_change();
        obs_t e, got;
        div_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            timer_en = (k < 9);
            div_val  = (k < 6) ? 4'd3 : 4'd1;
            case (k)
                6:       sb_q.push_back(mk(S_RUN,  1'b0, 1'b1, 64'd1));
                7:       sb_q.push_back(mk(S_RUN,  1'b0, 1'b0, 64'd1));
                8:       sb_q.push_back(mk(S_RUN,  1'b0, 1'b1, 64'd2));
                9:       sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
                default: sb_q.push_back(mk(S_RUN,  1'b0, 1'b0, 64'd0));
            endcase
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL div_change[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
        div_en = 1'b0; div_val = 4'd0;
    endtask

    task automatic test_write_priority();
        obs_t e, got;
        div_en = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; pwdata = 32'd0;
            timer_en = (k >= 2) && (k <= 9);
            case (k)
                0: begin
                    tdr1_wr_sel = 1'b1; pwdata = 32'hFFFF_FFFF;
                    sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000));
                end
                1: begin
                    tdr0_wr_sel = 1'b1; pwdata = 32'hFFFF_FFFE;
                    sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
                end
                2: sb_q.push_back(mk(S_RUN, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
                3: sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF));
                4: sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'd0));
                5: sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'd1));
                6: begin
                    tdr0_wr_sel = 1'b1; tdr1_wr_sel = 1'b1; pwdata = 32'hA5A5_0001;
                    sb_q.push_back(mk(S_RUN, 1'b0, 1'b0, 64'hA5A5_0001_A5A5_0001));
                end
                7: sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'hA5A5_0001_A5A5_0002));
                8: begin
                    tdr0_wr_sel = 1'b1; pwdata = 32'h0000_0100;
                    sb_q.push_back(mk(S_RUN, 1'b0, 1'b0, 64'hA5A5_0001_0000_0100));
                end
                9: sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'hA5A5_0001_0000_0101));
                10: begin
                    tdr0_wr_sel = 1'b1; pwdata = 32'h0000_1234;
                    sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
                end
                11: begin
                    tdr0_wr_sel = 1'b1; pwdata = 32'h0000_0055;
                    sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'h55));
                end
                default: begin
                    tdr0_wr_sel = 1'b1; pwdata = 32'd0;
                    sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
                end
            endcase
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL write_priority[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
        tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; pwdata = 32'd0;
    endtask

    task automatic test_halt();
        obs_t e, got;
        div_en = 1'b0;
        for (int k = 0; k < 21; k++) begin
            timer_en = (k < 20);
            halt_req = (k >= 6 && k <= 12) || (k >= 16);
            dbg_mode = (k >= 6 && k <= 8) || (k >= 19);
            if (k <= 5)
                sb_q.push_back(mk(S_RUN, 1'b0, k > 0, 64'(k)));
            else if (k <= 12)
                sb_q.push_back(mk(S_HALT, 1'b1, 1'b0, 64'd5));
            else if (k == 13)
                sb_q.push_back(mk(S_RUN, 1'b0, 1'b0, 64'd5));
            else if (k <= 18)
                sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'(k - 8)));
            else if (k == 19)
                sb_q.push_back(mk(S_HALT, 1'b1, 1'b0, 64'd10));
            else
                sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
        halt_req = 1'b0; dbg_mode = 1'b0;
    endtask

    task automatic test_halt_resume();
        obs_t e, got;
        div_en = 1'b1; div_val = 4'd2; dbg_mode = 1'b1;
        for (int k = 0; k < 14; k++) begin
            timer_en = (k < 13);
            halt_req = (k >= 3) && (k <= 5);
            if (k == 13)
                sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            else if (k >= 3 && k <= 5)
                sb_q.push_back(mk(S_HALT, 1'b1, 1'b0, 64'd0));
            else
                sb_q.push_back(mk(S_RUN, 1'b0, (k == 8) || (k == 12),
                                  (k >= 12) ? 64'd2 : (k >= 8) ? 64'd1 : 64'd0));
            cyc();
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL halt_resume[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
        div_en = 1'b0; div_val = 4'd0; dbg_mode = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_reset_mid_halt();
        obs_t e, got;
        div_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            timer_en = (k < 9);
            halt_req = (k == 4) || (k == 5);
            dbg_mode = (k == 4) || (k == 5);
            if (k <= 3)
                sb_q.push_back(mk(S_RUN, 1'b0, k > 0, 64'(k)));
            else if (k == 4)
                sb_q.push_back(mk(S_HALT, 1'b1, 1'b0, 64'd3));
            else if (k == 7)
                sb_q.push_back(mk(S_RUN, 1'b0, 1'b0, 64'd0));
            else if (k == 8)
                sb_q.push_back(mk(S_RUN, 1'b0, 1'b1, 64'd1));
            else
                sb_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 64'd0));
            if (k == 7) rst_n = 1'b1;
            if (k == 5) begin
                #2;
                rst_n = 1'b0;
                #1;
            end else begin
                cyc();
            end
            e = sb_q.pop_front(); got = cur(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_halt[%0d]: got st=%0d ack=%b en=%b cnt=%h, want st=%0d ack=%b en=%b cnt=%h",
                         k, got[67:66], got[65], got[64], got[63:0], e[67:66], e[65], e[64], e[63:0]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        timer_en    = 1'b0;
        div_en      = 1'b0;
        div_val     = 4'd0;
        halt_req    = 1'b0;
        dbg_mode    = 1'b0;
        tdr0_wr_sel = 1'b0;
        tdr1_wr_sel = 1'b0;
        pwdata      = 32'd0;

        test_reset();
        test_basic_count();
        test_prescale();
        test_div_change();
        test_write_priority();
        test_halt();
        test_halt_resume();
        test_reset_mid_halt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
